// File: rtl/data_mem_responder_if.sv
// Processor-to-data-memory handshake bundle: one request channel and one response channel.
// The processor side uses the master modport and the memory responder uses the slave modport.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding RISC-V data memory responder with fixed response latency,
// byte/half/word access checking and a register-file memory that clears on reset.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 2
) (
    input  logic               clk,
    input  logic               rst,
    data_mem_responder_if.slave bus
);
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_reg;
    logic [2:0]  cnt_reg;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] wdata_reg;
    logic        rsp_valid_reg;
    logic [31:0] rsp_rdata_reg;
    logic        rsp_err_reg;

    logic [31:0]   mem_rd [DEPTH_WORDS];
    logic [IW-1:0] word_idx;
    logic          out_of_range;
    logic          acc_err;
    logic          access_now;
    logic          commit;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_data;
    logic [3:0]    st_be;
    logic [31:0]   st_data;

    assign word_idx     = addr_reg[IW+1:2];
    assign out_of_range = {2'b00, addr_reg[31:2]} >= 32'(DEPTH_WORDS);

    always_comb begin
        acc_err = 1'b0;
        case (funct3_reg)
            3'b000:  acc_err = 1'b0;
            3'b001:  acc_err = addr_reg[0];
            3'b010:  acc_err = (addr_reg[1:0] != 2'b00);
            3'b100:  acc_err = we_reg;
            3'b101:  acc_err = we_reg | addr_reg[0];
            default: acc_err = 1'b1;
        endcase
        if (out_of_range) acc_err = 1'b1;
    end

    // The access happens on the edge that leaves the last WAIT cycle, so even
    // LATENCY=1 spends one cycle in WAIT and rsp_valid rises LATENCY edges after accept.
    assign access_now = (state_reg == WAIT) && (cnt_reg == 3'd0);
    assign commit     = access_now && we_reg && !acc_err;

    assign rd_word = mem_rd[word_idx];
    assign rd_byte = rd_word[{addr_reg[1:0], 3'b000} +: 8];
    assign rd_half = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = 32'd0;
        case (funct3_reg)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, rd_byte};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        st_be   = 4'b1111;
        st_data = wdata_reg;
        case (funct3_reg[1:0])
            2'b00: begin
                st_be   = 4'b0001 << addr_reg[1:0];
                st_data = {4{wdata_reg[7:0]}};
            end
            2'b01: begin
                st_be   = addr_reg[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata_reg[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = wdata_reg;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH_WORDS; gi++) begin : g_word
            logic [31:0] word_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    word_reg <= '0;
                end else if (commit && (word_idx == IW'(gi))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (st_be[b]) word_reg[8*b +: 8] <= st_data[8*b +: 8];
                    end
                end
            end
            assign mem_rd[gi] = word_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 3'd0;
            we_reg        <= 1'b0;
            addr_reg      <= 32'd0;
            funct3_reg    <= 3'd0;
            wdata_reg     <= 32'd0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_reg     <= bus.req_we;
                        addr_reg   <= bus.req_addr;
                        funct3_reg <= bus.req_funct3;
                        wdata_reg  <= bus.req_wdata;
                        cnt_reg    <= CNT_INIT;
                        state_reg  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg == 3'd0) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= acc_err;
                        rsp_rdata_reg <= (acc_err || we_reg) ? 32'd0 : load_data;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_reg == IDLE) && !rst;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance for data paths, errors,
// backpressure and mid-transaction reset, and a LATENCY=1 instance for throughput.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst;
    logic rst1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    data_mem_responder_if bus ();
    data_mem_responder_if bus1 ();

    data_mem_responder #(.DEPTH_WORDS(32), .LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    data_mem_responder #(.DEPTH_WORDS(32), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One complete transaction on the LATENCY=2 instance with its expected outcome.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        n = 0;
        @(negedge clk);
        check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_funct3 = f3;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFC;
        bus.req_wdata = 32'h0BAD_0BAD;
        while (n < 16) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.rsp_valid) break;
        end
        check({tag, ".lat"}, 32'(n), 32'd2);
        check({tag, ".rdata"}, bus.rsp_rdata, exp_rdata);
        check({tag, ".err"}, 32'(bus.rsp_err), 32'(exp_err));
        $display("txn %-10s we=%0d addr=%08h f3=%03b rdata=%08h err=%0d lat=%0d",
                 tag, we, addr, f3, bus.rsp_rdata, bus.rsp_err, n);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check({tag, ".done"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] ready_vec;
        logic [11:0] valid_vec;
        int acc_n;
        int rsp_n;
        int n;

        rst  = 1'b1;
        rst1 = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_we      = 1'b0;
        bus.req_addr    = 32'd0;
        bus.req_funct3  = 3'd0;
        bus.req_wdata   = 32'd0;
        bus.rsp_ready   = 1'b0;
        bus1.req_valid  = 1'b0;
        bus1.req_we     = 1'b0;
        bus1.req_addr   = 32'd0;
        bus1.req_funct3 = 3'd0;
        bus1.req_wdata  = 32'd0;
        bus1.rsp_ready  = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.ready", 32'(bus.req_ready), 32'd0);
        check("rst.valid", 32'(bus.rsp_valid), 32'd0);
        check("rst.rdata", bus.rsp_rdata, 32'd0);
        check("rst.err", 32'(bus.rsp_err), 32'd0);
        rst  = 1'b0;
        rst1 = 1'b0;
        #1;
        check("rst.ready_after", 32'(bus.req_ready), 32'd1);
        check("rst1.ready_after", 32'(bus1.req_ready), 32'd1);

        do_req("sw8",     1'b1, 32'h08, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0);
        do_req("lw8",     1'b0, 32'h08, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0);
        do_req("sb9",     1'b1, 32'h09, 3'b000, 32'h00000080, 32'h0,        1'b0);
        do_req("lb9",     1'b0, 32'h09, 3'b000, 32'h0,        32'hFFFFFF80, 1'b0);
        do_req("lbu9",    1'b0, 32'h09, 3'b100, 32'h0,        32'h00000080, 1'b0);
        do_req("lw8b",    1'b0, 32'h08, 3'b010, 32'h0,        32'hDEAD80EF, 1'b0);
        do_req("shE",     1'b1, 32'h0E, 3'b001, 32'h1234ABCD, 32'h0,        1'b0);
        do_req("lhE",     1'b0, 32'h0E, 3'b001, 32'h0,        32'hFFFFABCD, 1'b0);
        do_req("lhuE",    1'b0, 32'h0E, 3'b101, 32'h0,        32'h0000ABCD, 1'b0);
        do_req("lwC",     1'b0, 32'h0C, 3'b010, 32'h0,        32'hABCD0000, 1'b0);
        do_req("lh3",     1'b0, 32'h03, 3'b001, 32'h0,        32'h0,        1'b1);
        do_req("sw80",    1'b1, 32'h80, 3'b010, 32'h55AA55AA, 32'h0,        1'b1);
        do_req("lw7C",    1'b0, 32'h7C, 3'b010, 32'h0,        32'h0,        1'b0);
        do_req("lw0",     1'b0, 32'h00, 3'b010, 32'h0,        32'h0,        1'b0);
        do_req("sbu0",    1'b1, 32'h00, 3'b100, 32'h000000FF, 32'h0,        1'b1);
        do_req("f3_011",  1'b0, 32'h00, 3'b011, 32'h0,        32'h0,        1'b1);
        do_req("lw2",     1'b0, 32'h02, 3'b010, 32'h0,        32'h0,        1'b1);
        do_req("lwhigh",  1'b0, 32'h10000008, 3'b010, 32'h0,  32'h0,        1'b1);
        do_req("lw0b",    1'b0, 32'h00, 3'b010, 32'h0,        32'h0,        1'b0);

        // Backpressure: response held for 5 cycles while stray requests toggle.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h08;
        bus.req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (n < 16) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.rsp_valid) break;
        end
        check("bp.lat", 32'(n), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req_valid  = ~bus.req_valid;
            bus.req_we     = 1'b1;
            bus.req_addr   = 32'(i * 4);
            bus.req_funct3 = 3'b010;
            bus.req_wdata  = 32'hA5A5_0000 + 32'(i);
            check("bp.valid", 32'(bus.rsp_valid), 32'd1);
            check("bp.rdata", bus.rsp_rdata, 32'hDEAD80EF);
            check("bp.err", 32'(bus.rsp_err), 32'd0);
            check("bp.ready", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("bp.done", 32'(bus.rsp_valid), 32'd0);
        $display("txn backpressure held 5 cycles rdata=DEAD80EF");
        do_req("bp.lw0", 1'b0, 32'h00, 3'b010, 32'h0, 32'h0, 1'b0);
        do_req("bp.lw4", 1'b0, 32'h04, 3'b010, 32'h0, 32'h0, 1'b0);

        // Reset one cycle after accepting a store.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_addr   = 32'h10;
        bus.req_funct3 = 3'b010;
        bus.req_wdata  = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst.valid", 32'(bus.rsp_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mrst.valid_later", 32'(bus.rsp_valid), 32'd0);
        $display("txn mid-transaction reset on sw 0x10");
        do_req("mrst.lw10", 1'b0, 32'h10, 3'b010, 32'h0, 32'h0, 1'b0);
        do_req("mrst.lw8",  1'b0, 32'h08, 3'b010, 32'h0, 32'h0, 1'b0);

        // LATENCY=1 instance with rsp_ready tied high and req_valid held high.
        acc_n = 0;
        rsp_n = 0;
        ready_vec = '0;
        valid_vec = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ready_vec[k] = bus1.req_ready;
            valid_vec[k] = bus1.rsp_valid;
            if (bus1.rsp_valid) begin
                check("l1.rdata", bus1.rsp_rdata, (rsp_n == 0) ? 32'h0 : 32'hCAFEF00D);
                check("l1.err", 32'(bus1.rsp_err), 32'd0);
                $display("txn l1 rsp %0d rdata=%08h", rsp_n, bus1.rsp_rdata);
                rsp_n++;
            end
            if (bus1.req_ready) begin
                bus1.req_valid  = 1'b1;
                bus1.req_we     = (acc_n == 0);
                bus1.req_addr   = 32'h04;
                bus1.req_funct3 = 3'b010;
                bus1.req_wdata  = 32'hCAFEF00D;
                acc_n++;
            end
        end
        bus1.req_valid = 1'b0;
        check("l1.accept_pattern", 32'(ready_vec), 32'h249);
        check("l1.valid_pattern", 32'(valid_vec), 32'h924);
        check("l1.responses", 32'(rsp_n), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
